// File: rtl/weight_fetch.sv
// weight_fetch: producer side of the weight FIFO handshake.
// On start_i it reads num_rows_i consecutive 32-byte rows from weight memory,
// starting at base_addr_i. Rows land in a small prefetch buffer whose head is
// presented to the FIFO, so a row can be delivered in the same cycle the FIFO
// asks for one.
// Optional feature: define WEIGHT_FETCH_TILE_PAD_EN to round every job up to a
// multiple of 32 rows. The extra rows are all-zero and cost no memory reads.
module weight_fetch #(
    parameter int ADDR_W   = 16,
    parameter int MEM_LAT  = 1,
    parameter int PF_DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [ADDR_W-1:0]      base_addr_i,
    input  logic [15:0]            num_rows_i,
    input  logic                   request_data_i,
    output logic                   write_en_o,
    output logic                   sending_data_o,
    output logic [31:0][7:0]       data_o,
    output logic                   mem_rd_en_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    input  logic [31:0][7:0]       mem_data_i,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int PTR_W = (PF_DEPTH > 1) ? $clog2(PF_DEPTH) : 1;
    localparam int OCC_W = $clog2(PF_DEPTH + 1);
    // Row counts need one bit more than num_rows_i so a padded total of 65536 fits.
    localparam int CNT_W = 17;
    // Wide enough for occupancy + every in-flight slot without overflow.
    localparam int SUM_W = $clog2(PF_DEPTH + MEM_LAT + 2) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Control state
    state_t              state_q;
    logic                busy_q;
    logic                wr_en_q;
    logic                done_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [CNT_W-1:0]    slot_cnt_q;   // row slots granted so far (reads and pads)
    logic [CNT_W-1:0]    acc_cnt_q;    // rows accepted by the FIFO so far
    logic [CNT_W-1:0]    total_q;      // rows this job delivers
    logic [CNT_W-1:0]    total_req;    // total computed from the incoming command

    // Memory in-flight tracking
    logic [MEM_LAT-1:0]  inflight_q;
    logic [MEM_LAT-1:0]  inflight_d;
    logic [SUM_W-1:0]    inflight_cnt;
    logic [SUM_W-1:0]    credit_used;
    logic                credit_ok;
    logic                slot_grant;
    logic                rd_issue;

    // Prefetch buffer
    logic [31:0][7:0]    pf_mem_q [PF_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_d;
    logic [OCC_W-1:0]    occ_q;
    logic [OCC_W-1:0]    occ_d;
    logic                push;
    logic                pop;
    logic                accept;
    logic [31:0][7:0]    push_data;

    // Count the reads still travelling through the memory pipeline.
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            inflight_cnt = inflight_cnt + SUM_W'(inflight_q[i]);
        end
    end

    // Credit is conservative: a pop in the same cycle does not free a slot.
    assign credit_ok = (credit_used < SUM_W'(PF_DEPTH));

`ifdef WEIGHT_FETCH_TILE_PAD_EN
    logic [15:0] rows_q;         // real rows of the job; slots beyond are padding
    logic        pad_q;          // a padding slot was granted last cycle
    logic        slot_is_mem;
    logic        pad_order_ok;
    logic        pad_grant;

    assign total_req   = ({1'b0, num_rows_i} + CNT_W'(31)) & ~CNT_W'(31);
    assign slot_is_mem = (slot_cnt_q < {1'b0, rows_q});

    // A zero row pushes one cycle after its grant. With a deeper memory pipe an
    // earlier read could still be behind it, so hold padding until only the
    // last pipeline stage (which pushes this very edge) may be occupied.
    generate
        if (MEM_LAT > 1) begin : g_pad_order
            assign pad_order_ok = (inflight_q[MEM_LAT-2:0] == '0);
        end else begin : g_pad_order_any
            assign pad_order_ok = 1'b1;
        end
    endgenerate

    assign credit_used = SUM_W'(occ_q) + inflight_cnt + SUM_W'(pad_q);
    assign slot_grant  = (state_q == S_FETCH) && credit_ok && (slot_is_mem || pad_order_ok);
    assign rd_issue    = slot_grant && slot_is_mem;
    assign pad_grant   = slot_grant && !slot_is_mem;
    assign push        = inflight_q[MEM_LAT-1] | pad_q;
    assign push_data   = pad_q ? '0 : mem_data_i;

    // Remember the real row count and delay padding grants by one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rows_q <= '0;
            pad_q  <= 1'b0;
        end else begin
            pad_q <= pad_grant;
            if ((state_q == S_IDLE) && start_i) begin
                rows_q <= num_rows_i;
            end
        end
    end
`else
    assign total_req   = {1'b0, num_rows_i};
    assign credit_used = SUM_W'(occ_q) + inflight_cnt;
    assign slot_grant  = (state_q == S_FETCH) && credit_ok;
    assign rd_issue    = slot_grant;
    assign push        = inflight_q[MEM_LAT-1];
    assign push_data   = mem_data_i;
`endif

    // In-flight valid pipe: one stage per cycle of memory latency.
    assign inflight_d[0] = rd_issue;
    generate
        for (genvar gi = 1; gi < MEM_LAT; gi++) begin : g_lat
            assign inflight_d[gi] = inflight_q[gi-1];
        end
    endgenerate

    // Advance the in-flight pipe; reset drops anything still returning.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    // The FIFO accepts whenever it requests and we hold a row.
    assign accept = request_data_i && (occ_q != '0);
    assign pop    = accept;

    // Next-state for the buffer pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(PF_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(PF_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Buffer pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Buffer storage is flops, not block RAM: the head must be readable in the
    // same cycle without a read-latency stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < PF_DEPTH; i++) begin
                pf_mem_q[i] <= '0;
            end
        end else if (push) begin
            pf_mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Job sequencing, address and row counters, and the registered status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            slot_cnt_q <= '0;
            acc_cnt_q  <= '0;
            total_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        addr_q     <= base_addr_i;
                        slot_cnt_q <= '0;
                        acc_cnt_q  <= '0;
                        total_q    <= total_req;
                        busy_q     <= 1'b1;
                        if (num_rows_i == 16'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_FETCH;
                            wr_en_q <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (rd_issue) begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                    if (accept) begin
                        acc_cnt_q <= acc_cnt_q + CNT_W'(1);
                    end
                    if (slot_grant) begin
                        slot_cnt_q <= slot_cnt_q + CNT_W'(1);
                        if (slot_cnt_q == total_q - CNT_W'(1)) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (accept) begin
                        acc_cnt_q <= acc_cnt_q + CNT_W'(1);
                        if (acc_cnt_q == total_q - CNT_W'(1)) begin
                            state_q <= S_DONE;
                            wr_en_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    wr_en_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o         = busy_q;
    assign write_en_o     = wr_en_q;
    assign done_o         = done_q;
    assign mem_rd_en_o    = rd_issue;
    assign mem_addr_o     = addr_q;
    assign sending_data_o = (occ_q != '0);
    assign data_o         = (occ_q != '0) ? pf_mem_q[rd_ptr_q] : '0;

    // A push into a full buffer would lose a row; the credit rule forbids it.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        (push && !pop) |-> (occ_q < OCC_W'(PF_DEPTH)));

endmodule

// File: tb/tb_weight_fetch.sv
// Directed testbench for weight_fetch (default parameters, MEM_LAT = 1).
// Memory model: row n returns byte n[7:0] in every lane, one cycle after the read.
`timescale 1ns/1ps
module tb_weight_fetch;

    localparam int ADDR_W = 16;

    logic                clk = 1'b0;
    logic                rst_i;
    logic                start_i;
    logic [ADDR_W-1:0]   base_addr_i;
    logic [15:0]         num_rows_i;
    logic                request_data_i;
    logic                write_en_o;
    logic                sending_data_o;
    logic [31:0][7:0]    data_o;
    logic                mem_rd_en_o;
    logic [ADDR_W-1:0]   mem_addr_o;
    logic [31:0][7:0]    mem_data_i;
    logic                busy_o;
    logic                done_o;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int start_edge = 0;
    bit mon_en = 1'b0;
    logic [31:0][7:0]  acc_q[$];
    int                acc_cyc_q[$];
    logic [ADDR_W-1:0] rd_addr_q[$];
    int done_cnt, done_cyc, outstanding, max_out, credit_viol, rel;

    always #5 clk = ~clk;

    weight_fetch #(.ADDR_W(ADDR_W), .MEM_LAT(1), .PF_DEPTH(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .base_addr_i    (base_addr_i),
        .num_rows_i     (num_rows_i),
        .request_data_i (request_data_i),
        .write_en_o     (write_en_o),
        .sending_data_o (sending_data_o),
        .data_o         (data_o),
        .mem_rd_en_o    (mem_rd_en_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_i     (mem_data_i),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    function automatic logic [31:0][7:0] fill(input logic [7:0] b);
        logic [31:0][7:0] r;
        for (int i = 0; i < 32; i++) r[i] = b;
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Weight memory with one cycle of latency; junk pattern when not reading.
    always @(posedge clk) begin
        if (mem_rd_en_o) mem_data_i <= fill(mem_addr_o[7:0]);
        else             mem_data_i <= fill(8'hEE);
    end

    // Record reads, accepts and done pulses; track reads not yet accepted.
    always @(negedge clk) begin
        if (mon_en) begin
            rel = cyc - start_edge + 1;
            if (mem_rd_en_o) begin
                if (outstanding >= 4) credit_viol++;
                rd_addr_q.push_back(mem_addr_o);
            end
            if (request_data_i && sending_data_o) begin
                acc_q.push_back(data_o);
                acc_cyc_q.push_back(rel);
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = rel;
            end
            outstanding = outstanding + int'(mem_rd_en_o) - int'(request_data_i && sending_data_o);
            if (outstanding > max_out) max_out = outstanding;
        end
    end

    task automatic clear_mon();
        mon_en = 1'b0;
        acc_q.delete();
        acc_cyc_q.delete();
        rd_addr_q.delete();
        done_cnt = 0; done_cyc = 0; outstanding = 0; max_out = 0; credit_viol = 0;
    endtask

    // Issue one job and wait (bounded) for its done pulse.
    task automatic run_job(input logic [15:0] base, input logic [15:0] n,
                           input bit rnd, input bit inject, output bit fin);
        clear_mon();
        @(posedge clk); #1;
        base_addr_i = base; num_rows_i = n; start_i = 1'b1;
        request_data_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        start_edge = cyc; mon_en = 1'b1;
        start_i = 1'b0; base_addr_i = '0; num_rows_i = '0;
        fin = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (done_cnt > 0) begin
                fin = 1'b1;
                break;
            end
            if (inject) begin
                start_i     = (k == 2);
                base_addr_i = (k == 2) ? 16'h0080 : 16'h0000;
                num_rows_i  = (k == 2) ? 16'd2 : 16'd0;
            end
            if (rnd) request_data_i = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b0; request_data_i = 1'b0;
        base_addr_i = '0; num_rows_i = '0;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (write_en_o !== 1'b0) begin bad++; $display("FAIL reset_write_en: got %b want 0", write_en_o); end
            total++; if (sending_data_o !== 1'b0) begin bad++; $display("FAIL reset_sending: got %b want 0", sending_data_o); end
            total++; if (data_o !== fill(8'h00)) begin bad++; $display("FAIL reset_data: got %h want 0", data_o); end
            total++; if (mem_rd_en_o !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b want 0", mem_rd_en_o); end
            total++; if (mem_addr_o !== 16'h0000) begin bad++; $display("FAIL reset_addr: got %h want 0000", mem_addr_o); end
            total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
            total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done_o); end
        end
        $display("reset: checked outputs idle for 3 cycles");
    endtask

    task automatic test_basic();
        bit fin;
        run_job(16'h0010, 16'd8, 1'b0, 1'b0, fin);
        total++; if (!fin) begin bad++; $display("FAIL basic_timeout: got no done want done"); end
        total++; if (acc_q.size() != 8) begin bad++; $display("FAIL basic_accepts: got %0d want 8", acc_q.size()); end
        for (int i = 0; i < acc_q.size() && i < 8; i++) begin
            total++; if (acc_q[i] !== fill(8'(8'h10 + i))) begin bad++; $display("FAIL basic_data[%0d]: got %h want lanes %h", i, acc_q[i], 8'(8'h10 + i)); end
            total++; if (acc_cyc_q[i] != 3 + i) begin bad++; $display("FAIL basic_acc_cycle[%0d]: got %0d want %0d", i, acc_cyc_q[i], 3 + i); end
        end
        total++; if (rd_addr_q.size() != 8) begin bad++; $display("FAIL basic_reads: got %0d want 8", rd_addr_q.size()); end
        for (int i = 0; i < rd_addr_q.size() && i < 8; i++) begin
            total++; if (rd_addr_q[i] !== 16'(16'h0010 + i)) begin bad++; $display("FAIL basic_addr[%0d]: got %h want %h", i, rd_addr_q[i], 16'(16'h0010 + i)); end
        end
        total++; if (done_cyc != 11) begin bad++; $display("FAIL basic_done_cycle: got %0d want 11", done_cyc); end
        @(negedge clk);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL basic_busy_fall: got %b want 0", busy_o); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
        $display("basic: %0d rows accepted, done at cycle %0d", acc_q.size(), done_cyc);
    endtask

    task automatic test_backpressure();
        bit fin;
        run_job(16'h0100, 16'd20, 1'b1, 1'b0, fin);
        request_data_i = 1'b0;
        total++; if (!fin) begin bad++; $display("FAIL bp_timeout: got no done want done"); end
        total++; if (acc_q.size() != 20) begin bad++; $display("FAIL bp_accepts: got %0d want 20", acc_q.size()); end
        for (int i = 0; i < acc_q.size() && i < 20; i++) begin
            total++; if (acc_q[i] !== fill(8'(i))) begin bad++; $display("FAIL bp_data[%0d]: got %h want lanes %h", i, acc_q[i], 8'(i)); end
        end
        total++; if (rd_addr_q.size() != 20) begin bad++; $display("FAIL bp_reads: got %0d want 20", rd_addr_q.size()); end
        total++; if (max_out > 4) begin bad++; $display("FAIL bp_max_outstanding: got %0d want <=4", max_out); end
        total++; if (credit_viol != 0) begin bad++; $display("FAIL bp_read_without_credit: got %0d want 0", credit_viol); end
        $display("backpressure: %0d rows accepted, max outstanding %0d", acc_q.size(), max_out);
    endtask

    task automatic test_wrap();
        bit fin;
        logic [15:0] exp_a [4];
        exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
        run_job(16'hFFFE, 16'd4, 1'b0, 1'b0, fin);
        total++; if (!fin) begin bad++; $display("FAIL wrap_timeout: got no done want done"); end
        total++; if (rd_addr_q.size() != 4) begin bad++; $display("FAIL wrap_reads: got %0d want 4", rd_addr_q.size()); end
        for (int i = 0; i < rd_addr_q.size() && i < 4; i++) begin
            total++; if (rd_addr_q[i] !== exp_a[i]) begin bad++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, rd_addr_q[i], exp_a[i]); end
        end
        total++; if (acc_q.size() != 4) begin bad++; $display("FAIL wrap_accepts: got %0d want 4", acc_q.size()); end
        for (int i = 0; i < acc_q.size() && i < 4; i++) begin
            total++; if (acc_q[i] !== fill(exp_a[i][7:0])) begin bad++; $display("FAIL wrap_data[%0d]: got %h want lanes %h", i, acc_q[i], exp_a[i][7:0]); end
        end
        $display("wrap: addresses %h %h %h %h", exp_a[0], exp_a[1], exp_a[2], exp_a[3]);
    endtask

    task automatic test_zero_rows();
        bit fin;
        run_job(16'h0200, 16'd0, 1'b0, 1'b0, fin);
        total++; if (!fin) begin bad++; $display("FAIL zero_timeout: got no done want done"); end
        total++; if (done_cyc != 1) begin bad++; $display("FAIL zero_done_cycle: got %0d want 1", done_cyc); end
        total++; if (rd_addr_q.size() != 0) begin bad++; $display("FAIL zero_reads: got %0d want 0", rd_addr_q.size()); end
        total++; if (acc_q.size() != 0) begin bad++; $display("FAIL zero_accepts: got %0d want 0", acc_q.size()); end
        $display("zero_rows: done at cycle %0d", done_cyc);
    endtask

    task automatic test_start_busy();
        bit fin;
        run_job(16'h0020, 16'd6, 1'b0, 1'b1, fin);
        total++; if (!fin) begin bad++; $display("FAIL busy_start_timeout: got no done want done"); end
        repeat (4) @(negedge clk);
        total++; if (done_cnt != 1) begin bad++; $display("FAIL busy_start_done_count: got %0d want 1", done_cnt); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL busy_start_busy: got %b want 0", busy_o); end
        total++; if (acc_q.size() != 6) begin bad++; $display("FAIL busy_start_accepts: got %0d want 6", acc_q.size()); end
        for (int i = 0; i < acc_q.size() && i < 6; i++) begin
            total++; if (acc_q[i] !== fill(8'(8'h20 + i))) begin bad++; $display("FAIL busy_start_data[%0d]: got %h want lanes %h", i, acc_q[i], 8'(8'h20 + i)); end
        end
        total++; if (rd_addr_q.size() != 6) begin bad++; $display("FAIL busy_start_reads: got %0d want 6", rd_addr_q.size()); end
        for (int i = 0; i < rd_addr_q.size() && i < 6; i++) begin
            total++; if (rd_addr_q[i] !== 16'(16'h0020 + i)) begin bad++; $display("FAIL busy_start_addr[%0d]: got %h want %h", i, rd_addr_q[i], 16'(16'h0020 + i)); end
        end
        $display("start_busy: %0d rows, %0d done pulses", acc_q.size(), done_cnt);
    endtask

    task automatic test_reset_mid();
        bit fin;
        clear_mon();
        @(posedge clk); #1;
        base_addr_i = 16'h0030; num_rows_i = 16'd8; start_i = 1'b1; request_data_i = 1'b0;
        @(posedge clk); #1;                 // cycle 1
        start_i = 1'b0; base_addr_i = '0; num_rows_i = '0;
        @(posedge clk); #1;                 // cycle 2
        @(posedge clk); #1;                 // cycle 3, reads still returning
        rst_i = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (sending_data_o !== 1'b0) begin bad++; $display("FAIL rmid_sending_in_reset: got %b want 0", sending_data_o); end
        total++; if (data_o !== fill(8'h00)) begin bad++; $display("FAIL rmid_data_in_reset: got %h want 0", data_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rmid_busy_in_reset: got %b want 0", busy_o); end
        total++; if (write_en_o !== 1'b0) begin bad++; $display("FAIL rmid_write_en_in_reset: got %b want 0", write_en_o); end
        @(posedge clk); #1;
        rst_i = 1'b0; request_data_i = 1'b1;
        @(negedge clk);
        total++; if (sending_data_o !== 1'b0) begin bad++; $display("FAIL rmid_sending_after: got %b want 0", sending_data_o); end
        total++; if (mem_rd_en_o !== 1'b0) begin bad++; $display("FAIL rmid_rd_en_after: got %b want 0", mem_rd_en_o); end
        run_job(16'h0040, 16'd3, 1'b0, 1'b0, fin);
        total++; if (!fin) begin bad++; $display("FAIL rmid_timeout: got no done want done"); end
        total++; if (acc_q.size() != 3) begin bad++; $display("FAIL rmid_accepts: got %0d want 3", acc_q.size()); end
        for (int i = 0; i < acc_q.size() && i < 3; i++) begin
            total++; if (acc_q[i] !== fill(8'(8'h40 + i))) begin bad++; $display("FAIL rmid_data[%0d]: got %h want lanes %h", i, acc_q[i], 8'(8'h40 + i)); end
        end
        $display("reset_mid: new job delivered %0d rows", acc_q.size());
    endtask

`ifdef WEIGHT_FETCH_TILE_PAD_EN
    task automatic test_padding();
        bit fin;
        run_job(16'h0010, 16'd5, 1'b0, 1'b0, fin);
        total++; if (!fin) begin bad++; $display("FAIL pad_timeout: got no done want done"); end
        total++; if (acc_q.size() != 32) begin bad++; $display("FAIL pad_accepts: got %0d want 32", acc_q.size()); end
        for (int i = 0; i < acc_q.size() && i < 32; i++) begin
            logic [7:0] eb;
            eb = (i < 5) ? 8'(8'h10 + i) : 8'h00;
            total++; if (acc_q[i] !== fill(eb)) begin bad++; $display("FAIL pad_data[%0d]: got %h want lanes %h", i, acc_q[i], eb); end
        end
        total++; if (rd_addr_q.size() != 5) begin bad++; $display("FAIL pad_reads: got %0d want 5", rd_addr_q.size()); end
        $display("padding: %0d rows, %0d memory reads", acc_q.size(), rd_addr_q.size());
    endtask
`endif

    initial begin
        rst_i = 1'b1; start_i = 1'b0; request_data_i = 1'b0;
        base_addr_i = '0; num_rows_i = '0;
        test_reset();
`ifdef WEIGHT_FETCH_TILE_PAD_EN
        test_padding();
        test_zero_rows();
`else
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_rows();
        test_start_busy();
        test_reset_mid();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/weight_fetch.md
# weight_fetch

Streams weight rows from on-chip weight memory into the weight FIFO; it is the producer side of the FIFO's `write_en` / `request_data` / `sending_data` handshake. On a `start_i` command it reads `num_rows_i` consecutive 32-byte rows starting at `base_addr_i`. Read data lands in a small prefetch buffer, which lets the block present a row in the same cycle the FIFO requests one. It pulses `done_o` when the last row has been accepted.

## Interface
- `ADDR_W`, 16: weight memory address width (row granularity).
- `MEM_LAT`, 1: fixed weight memory read latency in cycles (1..4).
- `PF_DEPTH`, 4: prefetch buffer entries; must be ≥ `MEM_LAT`+2 for 1 row/cycle.

- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous reset, active-high.
- `start_i` in 1: command strobe; ignored while `busy_o`.
- `base_addr_i` in ADDR_W: first row address, sampled with `start_i`.
- `num_rows_i` in 16: rows to transfer, sampled with `start_i`.
- `request_data_i` in 1: FIFO can accept this cycle (`write_en_o` & FIFO not full).
- `write_en_o` out 1: wants to write; high in FETCH and DRAIN.
- `sending_data_o` out 1: `data_o` valid (prefetch buffer non-empty).
- `data_o` out [7:0] x32: prefetch buffer head; all zeros when empty.
- `mem_rd_en_o` out 1: memory read strobe.
- `mem_addr_o` out ADDR_W: memory read address.
- `mem_data_i` in [7:0] x32: read data, valid `MEM_LAT` cycles after `mem_rd_en_o`.
- `busy_o` out 1: state ≠ IDLE.
- `done_o` out 1: one-cycle pulse after the final row is accepted.

## Operation
- FSM: IDLE → FETCH on `start_i`, or → DONE if `num_rows_i`==0.
- FETCH → DRAIN when the final read is issued.
- DRAIN → DONE when the final row is accepted.
- DONE → IDLE unconditionally; `done_o`=1 only in DONE.
- Accept means `request_data_i` & `sending_data_o`. On accept, the buffer pops its head and the transfer count increments.
- Read issue in FETCH: issue when `occupancy + inflight < PF_DEPTH`. This is conservative and ignores a same-cycle pop. Each issue increments the address.
- Address wraps modulo 2^ADDR_W.
- In-flight tracking: `MEM_LAT`-deep valid shift register. A returning valid pushes `mem_data_i` into the buffer tail.
- Overflow is impossible by the credit rule. An assertion checks it.
- Simultaneous push and pop: occupancy unchanged, order preserved.
- Reset at any time:
  - FSM goes to IDLE; counters, buffer, and the in-flight shift register are cleared.
  - Data returning after reset is discarded.
  - All outputs go to 0; `data_o` goes to zeros.
- `start_i` while busy: ignored, with no side effects.

## Timing
- `start_i` is sampled at edge 0.
- First `mem_rd_en_o` at cycle 1; data is captured at the end of cycle 1+`MEM_LAT`.
- `sending_data_o` first rises in cycle 2+`MEM_LAT`, which is 3 with defaults.
- Steady state: 1 row/cycle while `request_data_i` is held and `PF_DEPTH` ≥ `MEM_LAT`+2.
- `request_data_i` is combinational from the FIFO. `sending_data_o` and `data_o` must be stable from register outputs, with no path from `request_data_i`.
- `done_o` appears the cycle after the accepting edge of the last row. `busy_o` falls the following cycle.

## Configuration
- `WEIGHT_FETCH_TILE_PAD_EN` defined:
  - Total rows delivered = ceil(`num_rows_i`/32)*32.
  - Rows beyond `num_rows_i` are pushed as all-zero entries with no memory read: no `mem_rd_en_o`, no address increment.
  - Padding rows obey the same credit rule and push one cycle after the slot is granted.
  - `num_rows_i`=0 still goes straight to DONE.
- Undefined: exactly `num_rows_i` rows are delivered and no padding logic exists.

## Test plan
- Reset check: `rst_i` high for 2 cycles, then low → all outputs 0 and `data_o`=0 until `start_i`.
- Basic transfer: `base_addr_i`=0x0010, `num_rows_i`=8, `request_data_i`=1 always, memory row n holds byte value n in every lane.
  - 8 accepts on consecutive cycles, starting cycle 3, with values 0x10..0x17.
  - `mem_addr_o` 0x10..0x17.
  - `done_o` pulse at cycle 11.
- Backpressure: `num_rows_i`=20, `request_data_i` toggled pseudo-randomly → exactly 20 accepts, in order, none lost or duplicated. Occupancy never exceeds 4 and no reads are issued while credit = 0.
- Wrap and edge cases:
  - `base_addr_i`=0xFFFE, `num_rows_i`=4 → addresses FFFE, FFFF, 0000, 0001.
  - `num_rows_i`=0 → `done_o` at cycle 1, no `mem_rd_en_o`.
  - `start_i` during busy → ignored.
- Reset mid-transfer: assert `rst_i` with 2 reads in flight, then start a new 3-row job → only the new job's 3 rows appear; stale data is never presented.
- Padding: with `WEIGHT_FETCH_TILE_PAD_EN`, `num_rows_i`=5 → 32 accepts; rows 5..31 are zeros; exactly 5 `mem_rd_en_o` pulses.
